// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush sequencer: bus widths,
// exception type codes and stall-vector bit positions.
package pipeline_ctrl_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned EXC_TYPE_W = 5;

    localparam logic [EXC_TYPE_W-1:0] EXC_NONE    = 5'd0;
    localparam logic [EXC_TYPE_W-1:0] EXC_INT     = 5'd1;
    localparam logic [EXC_TYPE_W-1:0] EXC_ADEL    = 5'd4;
    localparam logic [EXC_TYPE_W-1:0] EXC_SYSCALL = 5'd8;
    localparam logic [EXC_TYPE_W-1:0] EXC_RI      = 5'd10;
    localparam logic [EXC_TYPE_W-1:0] EXC_OV      = 5'd12;
    localparam logic [EXC_TYPE_W-1:0] EXC_ERET    = 5'd14;

    localparam int unsigned STALL_W     = 5;
    localparam int unsigned STALL_PC    = 0;
    localparam int unsigned STALL_IFID  = 1;
    localparam int unsigned STALL_IDEX  = 2;
    localparam int unsigned STALL_EXMEM = 3;
    localparam int unsigned STALL_MEMWB = 4;

    // Hold every register up to and including the requesting stage's own.
    function automatic logic [STALL_W-1:0] stall_upto(input int unsigned last_bit);
        logic [STALL_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < STALL_W; i++) begin
            if (i <= last_bit) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer: prioritises stage stall requests, flushes on
// exceptions and issues the PC redirect, deferring it while a fetch is in flight.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] EXC_ENTRY       = 32'hBFC00380,
    parameter int unsigned       STALL_CNT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall_req_if,
    input  logic                       stall_req_id,
    input  logic                       stall_req_ex,
    input  logic                       stall_req_mem,
    input  logic [EXC_TYPE_W-1:0]      exception_type_i,
    input  logic [DATA_W-1:0]          cp0_epc_i,
    output logic [STALL_W-1:0]         stall_o,
    output logic                       flush_o,
    output logic                       redirect_valid_o,
    output logic [ADDR_W-1:0]          redirect_pc_o,
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt_o
);

    typedef enum logic [0:0] {StIdle, StPend} state_e;

    state_e                     state_q, state_d;
    logic [ADDR_W-1:0]          pend_pc_q, pend_pc_d;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q;
    logic                       exc;
    logic [ADDR_W-1:0]          tgt;

    assign exc = (exception_type_i != EXC_NONE);
    assign tgt = (exception_type_i == EXC_ERET) ? cp0_epc_i : EXC_ENTRY;

    always_comb begin
        stall_o          = '0;
        flush_o          = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        state_d          = state_q;
        pend_pc_d        = pend_pc_q;
        // Outputs are forced quiet for the whole time reset is held.
        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    if (exc) begin
                        flush_o = 1'b1;
                        if (stall_req_if) begin
                            // Fetch still in flight: park the target until it completes.
                            stall_o   = stall_upto(STALL_PC);
                            pend_pc_d = tgt;
                            state_d   = StPend;
                        end else begin
                            redirect_valid_o = 1'b1;
                            redirect_pc_o    = tgt;
                        end
                    end else if (stall_req_mem) begin
                        stall_o = stall_upto(STALL_EXMEM);
                    end else if (stall_req_ex) begin
                        stall_o = stall_upto(STALL_IDEX);
                    end else if (stall_req_id) begin
                        stall_o = stall_upto(STALL_IFID);
                    end else if (stall_req_if) begin
                        stall_o = stall_upto(STALL_PC);
                    end
                end
                StPend: begin
                    if (stall_req_if) begin
                        stall_o = stall_upto(STALL_PC);
                    end else begin
                        flush_o          = 1'b1;
                        redirect_valid_o = 1'b1;
                        redirect_pc_o    = pend_pc_q;
                        state_d          = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if ((stall_o != '0) && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomised bench for pipeline_ctrl, checked against a behavioural model that
// tracks the pending redirect as a queue and the stall count as an integer.
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    localparam int unsigned CW    = 4;
    localparam logic [31:0] ENTRY = 32'hBFC00380;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  req_if, req_id, req_ex, req_mem;
    logic [EXC_TYPE_W-1:0] exc_type;
    logic [DATA_W-1:0]     epc;
    logic [STALL_W-1:0]    stall;
    logic                  flush, rv;
    logic [ADDR_W-1:0]     rpc;
    logic [CW-1:0]         cnt;

    int checks   = 0;
    int failures = 0;

    logic [31:0] pend_q[$];
    int unsigned m_cnt;

    pipeline_ctrl #(
        .EXC_ENTRY       (ENTRY),
        .STALL_CNT_WIDTH (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_req_if     (req_if),
        .stall_req_id     (req_id),
        .stall_req_ex     (req_ex),
        .stall_req_mem    (req_mem),
        .exception_type_i (exc_type),
        .cp0_epc_i        (epc),
        .stall_o          (stall),
        .flush_o          (flush),
        .redirect_valid_o (rv),
        .redirect_pc_o    (rpc),
        .stall_cnt_o      (cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic i_f, input logic i_d, input logic i_e, input logic i_m,
                         input logic [EXC_TYPE_W-1:0] t, input logic [31:0] e);
        req_if = i_f; req_id = i_d; req_ex = i_e; req_mem = i_m; exc_type = t; epc = e;
    endtask

    task automatic model_out(output logic [4:0] s, output logic f, output logic v,
                             output logic [31:0] pc);
        int k;
        s = '0; f = 1'b0; v = 1'b0; pc = '0;
        if (pend_q.size() != 0) begin
            if (req_if) s = 5'd1;
            else begin f = 1'b1; v = 1'b1; pc = pend_q[0]; end
        end else if (exc_type != EXC_NONE) begin
            f = 1'b1;
            if (req_if) s = 5'd1;
            else begin v = 1'b1; pc = (exc_type == EXC_ERET) ? epc : ENTRY; end
        end else begin
            k = req_mem ? 4 : req_ex ? 3 : req_id ? 2 : req_if ? 1 : 0;
            s = 5'((1 << k) - 1);
        end
    endtask

    // Check combinational outputs mid-cycle, advance one edge, then check the counter.
    task automatic cycle(input string tag);
        logic [4:0]  s;
        logic        f, v;
        logic [31:0] pc;
        #2;
        model_out(s, f, v, pc);
        check({tag, ".stall"}, 32'(stall), 32'(s));
        check({tag, ".flush"}, 32'(flush), 32'(f));
        check({tag, ".rv"}, 32'(rv), 32'(v));
        check({tag, ".rpc"}, rpc, pc);
        @(posedge clk);
        if (pend_q.size() != 0) begin
            if (!req_if) void'(pend_q.pop_front());
        end else if (exc_type != EXC_NONE && req_if) begin
            pend_q.push_back((exc_type == EXC_ERET) ? epc : ENTRY);
        end
        if (s != 0 && m_cnt < (1 << CW) - 1) m_cnt++;
        #1;
        check({tag, ".cnt"}, 32'(cnt), m_cnt);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".stall"}, 32'(stall), 0);
        check({tag, ".flush"}, 32'(flush), 0);
        check({tag, ".rv"}, 32'(rv), 0);
        check({tag, ".rpc"}, rpc, 0);
        check({tag, ".cnt"}, 32'(cnt), 0);
    endtask

    initial begin
        logic [EXC_TYPE_W-1:0] types [5];
        types = '{EXC_INT, EXC_SYSCALL, EXC_RI, EXC_OV, EXC_ERET};
        m_cnt = 0;
        rst = 1'b1;
        drive(1, 1, 1, 1, EXC_SYSCALL, 32'h1234_5678);
        #2;
        check_quiet("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        drive(0, 1, 1, 0, EXC_NONE, 0);         cycle("id_ex");
        drive(0, 1, 1, 1, EXC_NONE, 0);         cycle("id_ex_mem");
        drive(1, 0, 0, 0, EXC_NONE, 0);         cycle("if_only");
        drive(0, 0, 0, 0, EXC_SYSCALL, 0);      cycle("syscall");
        drive(0, 0, 0, 0, EXC_NONE, 0);         cycle("after_exc");
        drive(0, 0, 0, 0, EXC_ERET, 32'h8000_1234); cycle("eret");
        drive(1, 0, 0, 0, EXC_ERET, 32'h8000_0040); cycle("pend0");
        drive(1, 1, 0, 1, EXC_SYSCALL, 0);      cycle("pend1");
        drive(1, 0, 1, 0, EXC_NONE, 0);         cycle("pend2");
        drive(0, 0, 0, 0, EXC_NONE, 0);         cycle("pend_done");
        drive(0, 0, 0, 0, EXC_NONE, 0);         cycle("pend_idle");
        drive(0, 0, 0, 1, EXC_OV, 0);           cycle("exc_mem");
        drive(0, 0, 0, 0, EXC_INT, 0);          cycle("b2b_a");
        drive(0, 0, 0, 0, EXC_ERET, 32'hA0);    cycle("b2b_b");

        // Asynchronous reset while a redirect is pending.
        drive(1, 0, 0, 0, EXC_SYSCALL, 0);      cycle("rpend");
        drive(1, 0, 0, 0, EXC_NONE, 0);
        #2;
        rst = 1'b1;
        #1;
        check_quiet("rst_mid");
        @(posedge clk);
        #2;
        rst = 1'b0;
        pend_q.delete();
        m_cnt = 0;
        drive(0, 0, 0, 0, EXC_NONE, 0);         cycle("post_rst");
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 0, EXC_NONE, 0);     cycle("cnt4");
        end
        check("cnt_is_4", 32'(cnt), 4);

        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) == 0) ? types[$urandom_range(0, 4)] : EXC_NONE,
                  $urandom);
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage core. Collects stall requests from IF, ID, EX and MEM, plus the committed exception type from MEM.
- Drives the per-register stall vector and a common flush to every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and to the PC.
- Issues the PC redirect for exceptions and ERET. Holds a pending redirect while an instruction fetch is outstanding.

Parameters:
- EXC_ENTRY, 32'hBFC00380, general exception vector used for every non-ERET exception.
- STALL_CNT_WIDTH, 32, width of the saturating stall-cycle performance counter.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous reset, active-high
- stall_req_if  input  1  fetch not complete
- stall_req_id  input  1  load-use hazard
- stall_req_ex  input  1  multi-cycle mul/div busy
- stall_req_mem  input  1  data access not complete
- exception_type_i  input  `EXC_TYPE_BUS  exception type of the instruction in MEM; `EXC_NONE = no exception
- cp0_epc_i  input  `DATA_BUS  current EPC
- stall_o  output  5  hold enables: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB
- flush_o  output  1  clear all pipeline registers at the next edge
- redirect_valid_o  output  1  PC loads redirect_pc_o at the next edge
- redirect_pc_o  output  `ADDR_BUS  redirect target
- stall_cnt_o  output  STALL_CNT_WIDTH  cycles with stall_o != 0, saturating

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, pend_pc=0, stall_cnt=0. All outputs 0 while rst is asserted.
- stall_o, flush_o, redirect_* are combinational from inputs and state. Decisions take effect at the same clock edge (zero latency).
- Stall vector rule: the requesting stage and all earlier registers hold; the next register receives a bubble. Each pipeline register is wired with stall_current_stage=stall_o[i] and stall_next_stage=stall_o[i+1].
- Stall priority (IDLE, no exception):
  - mem -> 5'b01111
  - else ex -> 5'b00111
  - else id -> 5'b00011
  - else if -> 5'b00001
  - else 5'b00000
- Exception detect: exc = (exception_type_i != `EXC_NONE), evaluated in IDLE only.
- Exception target: tgt = cp0_epc_i if exception_type_i == `EXC_ERET, else EXC_ENTRY.
- IDLE, exc, stall_req_if=0:
  - flush_o=1, redirect_valid_o=1, redirect_pc_o=tgt, stall_o=0.
  - Stay in IDLE.
  - Exception overrides all stall requests, including stall_req_mem: the excepting access is cancelled.
- IDLE, exc, stall_req_if=1:
  - flush_o=1, stall_o=5'b00001, redirect_valid_o=0.
  - pend_pc<=tgt; go to PEND.
- PEND, stall_req_if=1:
  - stall_o=5'b00001, flush_o=0, redirect_valid_o=0.
  - exception_type_i and the other stall requests are ignored (the pipeline is empty).
- PEND, stall_req_if=0:
  - flush_o=1 (discards the wrong-path fetch result), redirect_valid_o=1, redirect_pc_o=pend_pc, stall_o=0.
  - Go to IDLE.
- redirect_pc_o = 0 whenever redirect_valid_o=0.
- stall_cnt:
  - Increments each cycle stall_o != 0.
  - Holds at all-ones (no wrap).
  - Cleared only by rst.
- Reset mid-PEND: pending redirect is dropped, state=IDLE, no redirect is emitted.
- Back-to-back exceptions in consecutive IDLE cycles: each is serviced independently. The second cannot normally occur because of the flush, but it must not corrupt state.

Decomposition:
- Shared constants in the global bus include: `EXC_NONE, `EXC_ERET, `EXC_TYPE_BUS, `ADDR_BUS, `DATA_BUS, and the stall-vector bit indices (`STALL_PC … `STALL_MEMWB).
- State encoding (IDLE/PEND) is a localparam inside the block.
- No sub-module is needed. The saturating counter may be a local always block.

Test Plan:
- Stall priority: stall_req_id=1 and stall_req_ex=1 together -> stall_o=5'b00111, flush_o=0. Then stall_req_mem=1 added -> 5'b01111.
- Plain exception: exception_type_i=syscall, stall_req_if=0 -> same cycle flush_o=1, redirect_valid_o=1, redirect_pc_o=32'hBFC00380. Next cycle all outputs 0.
- ERET: exception_type_i=`EXC_ERET, cp0_epc_i=32'h8000_1234 -> redirect_pc_o=32'h8000_1234, flush_o=1.
- Pending redirect: exception with stall_req_if=1 held for 3 cycles (EPC target 32'h8000_0040) -> flush_o=1 in the first cycle only, stall_o=5'b00001 for 3 cycles. On the cycle stall_req_if drops: flush_o=1, redirect_valid_o=1, redirect_pc_o=32'h8000_0040. Afterwards IDLE.
- Exception with stall_req_mem=1 -> stall_o=0, flush_o=1; the MEM stall is overridden.
- Reset during PEND: assert rst asynchronously mid-cycle -> outputs 0 immediately. After release, stall_req_if=0 produces no redirect. stall_cnt_o=0; it then counts 4 after 4 stalled cycles.
